ras_stack: RTL and testbench

- Return address stack for the fetch predictor.
- Fetch pushes link targets on predicted calls and pops predicted return targets on predicted returns.
- Fetch checkpoints the RAS pointer/count alongside branch info.
- On a mispredict, the backend restores the pointer/count so the speculative stack state realigns with the architectural path. Stack contents are not restored.

---
 rtl/ras_stack.sv | 131 +++++++++++++
 tb/tb_ras_stack.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_stack.sv
// Return address stack for the fetch predictor.
// Fetch pushes link targets on predicted calls and pops return targets on
// predicted returns. The backend can restore the TOS index and count after a
// mispredict; stack contents themselves are never rolled back.
module ras_stack #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ras_link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] ras_link_pc,
    input  logic                        ras_ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ras_ret_pc,
    output logic                        ras_empty,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    input  logic                        update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
    input  logic [RAS_INDEX_WIDTH:0]    update_ras_count
);

    localparam int CW = RAS_INDEX_WIDTH + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_ENTRIES);

    // One operation is selected per cycle; reset is applied in the registers.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_RESTORE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_e;

    logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  index_q, index_d;
    logic [CW-1:0]               count_q, count_d;
    op_e                         op;
    logic                        wr_en;
    logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
    logic [RAS_TARGET_WIDTH-1:0] wr_data;
    logic                        stack_nonempty;

    assign stack_nonempty = (count_q != '0);

    // Decode the request mix into a single operation, restore winning.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        op = OP_HOLD;
        if (update_valid) begin
            op = OP_RESTORE;
        end else if (ras_link_valid && ras_ret_valid) begin
            // Return-then-call replaces TOS in place; on an empty stack
            // there is nothing to return from, so it degrades to a push.
            op = stack_nonempty ? OP_REPLACE : OP_PUSH;
        end else if (ras_link_valid) begin
            op = OP_PUSH;
        end else if (ras_ret_valid && stack_nonempty) begin
            op = OP_POP;
        end
    end

    // Next pointer/count and the single entry write port for the chosen op.
    always_comb begin
        index_d = index_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = index_q;
        wr_data = ras_link_pc;
        case (op)
            OP_RESTORE: begin
                index_d = update_ras_index;
                count_d = (update_ras_count > FULL_COUNT) ? FULL_COUNT
                                                          : update_ras_count;
            end
            OP_PUSH: begin
                // Index wraps naturally; when full the oldest entry is
                // overwritten and the count stays saturated.
                index_d = index_q + 1'b1;
                count_d = (count_q == FULL_COUNT) ? count_q : count_q + 1'b1;
                wr_en   = 1'b1;
                wr_idx  = index_q + 1'b1;
            end
            OP_POP: begin
                index_d = index_q - 1'b1;
                count_d = count_q - 1'b1;
            end
            OP_REPLACE: begin
                wr_en  = 1'b1;
                wr_idx = index_q;
            end
            default: ;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            index_q <= '0;
            count_q <= '0;
        end else begin
            index_q <= index_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so ras_ret_pc reads zero afterwards.
    always_ff @(posedge CLK) begin
        // NOTE: resetting the array forces it into flops rather than a RAM
        // macro; acceptable here because the stack is small and a defined
        // post-reset read value is wanted.
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else if (wr_en) begin
            entry_q[wr_idx] <= wr_data;
        end
    end

    // Zero-latency TOS read and checkpoint outputs.
    assign ras_ret_pc = entry_q[index_q];
    assign ras_empty  = !stack_nonempty;
    assign ras_index  = index_q;
    assign ras_count  = count_q;

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: each scenario task drives one stimulus
// per cycle, queues the expected post-edge state and compares it when the
// DUT presents that state.
module tb_ras_stack;

    typedef struct packed {
        logic        rst;
        logic        link;
        logic [30:0] pc;
        logic        ret;
        logic        upd;
        logic [2:0]  ui;
        logic [3:0]  uc;
    } stim_t;

    typedef struct packed {
        logic [30:0] pc;
        logic        empty;
        logic [2:0]  idx;
        logic [3:0]  cnt;
    } state_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ras_link_valid = 1'b0;
    logic [30:0] ras_link_pc = '0;
    logic        ras_ret_valid = 1'b0;
    logic [30:0] ras_ret_pc;
    logic        ras_empty;
    logic [2:0]  ras_index;
    logic [3:0]  ras_count;
    logic        update_valid = 1'b0;
    logic [2:0]  update_ras_index = '0;
    logic [3:0]  update_ras_count = '0;

    int     n_vec = 0;
    int     n_bad = 0;
    state_t exp_q[$];

    ras_stack dut (
        .CLK             (CLK),
        .RST             (RST),
        .ras_link_valid  (ras_link_valid),
        .ras_link_pc     (ras_link_pc),
        .ras_ret_valid   (ras_ret_valid),
        .ras_ret_pc      (ras_ret_pc),
        .ras_empty       (ras_empty),
        .ras_index       (ras_index),
        .ras_count       (ras_count),
        .update_valid    (update_valid),
        .update_ras_index(update_ras_index),
        .update_ras_count(update_ras_count)
    );

    always #5 CLK = ~CLK;

    // Stimulus / expectation builders.
    function automatic stim_t s_rst();
        stim_t s = '0; s.rst = 1'b1; return s;
    endfunction
    function automatic stim_t s_idle();
        stim_t s = '0; return s;
    endfunction
    function automatic stim_t s_push(input logic [30:0] pc);
        stim_t s = '0; s.link = 1'b1; s.pc = pc; return s;
    endfunction
    function automatic stim_t s_pop();
        stim_t s = '0; s.ret = 1'b1; return s;
    endfunction
    function automatic stim_t s_both(input logic [30:0] pc);
        stim_t s = '0; s.link = 1'b1; s.ret = 1'b1; s.pc = pc; return s;
    endfunction
    function automatic stim_t s_upd(input logic [2:0] ui, input logic [3:0] uc,
                                    input logic link, input logic ret,
                                    input logic [30:0] pc);
        stim_t s = '0;
        s.upd = 1'b1; s.ui = ui; s.uc = uc;
        s.link = link; s.ret = ret; s.pc = pc;
        return s;
    endfunction
    function automatic state_t st(input logic [30:0] pc, input logic empty,
                                  input logic [2:0] idx, input logic [3:0] cnt);
        state_t e;
        e.pc = pc; e.empty = empty; e.idx = idx; e.cnt = cnt;
        return e;
    endfunction
    function automatic state_t observe();
        state_t o;
        o.pc = ras_ret_pc; o.empty = ras_empty; o.idx = ras_index; o.cnt = ras_count;
        return o;
    endfunction
    function automatic string fmt(input state_t v);
        return $sformatf("pc=%h empty=%b idx=%0d cnt=%0d", v.pc, v.empty, v.idx, v.cnt);
    endfunction

    task automatic apply(input stim_t s);
        RST              = s.rst;
        ras_link_valid   = s.link;
        ras_link_pc      = s.pc;
        ras_ret_valid    = s.ret;
        update_valid     = s.upd;
        update_ras_index = s.ui;
        update_ras_count = s.uc;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        stim_t  stim[$];
        state_t want[$];
        state_t got, exp;
        stim.push_back(s_rst());  want.push_back(st(31'h0, 1'b1, 3'd0, 4'd0));
        stim.push_back(s_idle()); want.push_back(st(31'h0, 1'b1, 3'd0, 4'd0));
        stim.push_back(s_idle()); want.push_back(st(31'h0, 1'b1, 3'd0, 4'd0));
        foreach (stim[i]) begin
            apply(stim[i]);
            exp_q.push_back(want[i]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_push_pop();
        stim_t  stim[$];
        state_t want[$];
        state_t got, exp;
        stim.push_back(s_rst());           want.push_back(st(31'h0,   1'b1, 3'd0, 4'd0));
        stim.push_back(s_push(31'h100));   want.push_back(st(31'h100, 1'b0, 3'd1, 4'd1));
        stim.push_back(s_push(31'h200));   want.push_back(st(31'h200, 1'b0, 3'd2, 4'd2));
        stim.push_back(s_push(31'h300));   want.push_back(st(31'h300, 1'b0, 3'd3, 4'd3));
        stim.push_back(s_pop());           want.push_back(st(31'h200, 1'b0, 3'd2, 4'd2));
        stim.push_back(s_pop());           want.push_back(st(31'h100, 1'b0, 3'd1, 4'd1));
        stim.push_back(s_pop());           want.push_back(st(31'h0,   1'b1, 3'd0, 4'd0));
        foreach (stim[i]) begin
            apply(stim[i]);
            exp_q.push_back(want[i]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL push_pop[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    // Ten pushes into eight entries: slots 0..2 end up holding 8, 9, 0xA and
    // slots 3..7 keep the values 3..7.
    task automatic test_overflow();
        stim_t  stim[$];
        state_t want[$];
        state_t got, exp;
        logic [30:0] slot [8];
        for (int k = 0; k < 8; k++) slot[k] = (k < 3) ? 31'(k + 8) : 31'(k);
        stim.push_back(s_rst()); want.push_back(st(31'h0, 1'b1, 3'd0, 4'd0));
        for (int k = 1; k <= 10; k++) begin
            stim.push_back(s_push(31'(k)));
            want.push_back(st(31'(k), 1'b0, 3'(k % 8), 4'((k > 8) ? 8 : k)));
        end
        for (int j = 1; j <= 8; j++) begin
            stim.push_back(s_pop());
            want.push_back(st(slot[(2 - j + 8) % 8], (j == 8), 3'((2 - j + 8) % 8), 4'(8 - j)));
        end
        stim.push_back(s_pop()); want.push_back(st(31'hA, 1'b1, 3'd2, 4'd0));
        foreach (stim[i]) begin
            apply(stim[i]);
            exp_q.push_back(want[i]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL overflow[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_replace();
        stim_t  stim[$];
        state_t want[$];
        state_t got, exp;
        stim.push_back(s_rst());         want.push_back(st(31'h0,  1'b1, 3'd0, 4'd0));
        stim.push_back(s_push(31'h20));  want.push_back(st(31'h20, 1'b0, 3'd1, 4'd1));
        stim.push_back(s_push(31'h40));  want.push_back(st(31'h40, 1'b0, 3'd2, 4'd2));
        stim.push_back(s_both(31'h80));  want.push_back(st(31'h80, 1'b0, 3'd2, 4'd2));
        stim.push_back(s_pop());         want.push_back(st(31'h20, 1'b0, 3'd1, 4'd1));
        stim.push_back(s_rst());         want.push_back(st(31'h0,  1'b1, 3'd0, 4'd0));
        stim.push_back(s_both(31'h55));  want.push_back(st(31'h55, 1'b0, 3'd1, 4'd1));
        foreach (stim[i]) begin
            apply(stim[i]);
            exp_q.push_back(want[i]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL replace[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_restore();
        stim_t  stim[$];
        state_t want[$];
        state_t got, exp;
        stim.push_back(s_rst());         want.push_back(st(31'h0,  1'b1, 3'd0, 4'd0));
        stim.push_back(s_push(31'h11));  want.push_back(st(31'h11, 1'b0, 3'd1, 4'd1));
        stim.push_back(s_push(31'h22));  want.push_back(st(31'h22, 1'b0, 3'd2, 4'd2));
        stim.push_back(s_push(31'h33));  want.push_back(st(31'h33, 1'b0, 3'd3, 4'd3));
        stim.push_back(s_push(31'h44));  want.push_back(st(31'h44, 1'b0, 3'd4, 4'd4));
        stim.push_back(s_push(31'h55));  want.push_back(st(31'h55, 1'b0, 3'd5, 4'd5));
        stim.push_back(s_upd(3'd3, 4'd3, 1'b1, 1'b0, 31'h99));
        want.push_back(st(31'h33, 1'b0, 3'd3, 4'd3));
        stim.push_back(s_upd(3'd3, 4'd3, 1'b0, 1'b1, 31'h0));
        want.push_back(st(31'h33, 1'b0, 3'd3, 4'd3));
        stim.push_back(s_pop());         want.push_back(st(31'h22, 1'b0, 3'd2, 4'd2));
        foreach (stim[i]) begin
            apply(stim[i]);
            exp_q.push_back(want[i]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL restore[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    // Continues from test_restore: slots 1..5 hold 0x11..0x55, others zero.
    task automatic test_clamp();
        stim_t  stim[$];
        state_t want[$];
        state_t got, exp;
        stim.push_back(s_upd(3'd6, 4'd15, 1'b0, 1'b0, 31'h0)); want.push_back(st(31'h0,  1'b0, 3'd6, 4'd8));
        stim.push_back(s_upd(3'd5, 4'd9,  1'b0, 1'b0, 31'h0)); want.push_back(st(31'h55, 1'b0, 3'd5, 4'd8));
        stim.push_back(s_upd(3'd4, 4'd8,  1'b0, 1'b0, 31'h0)); want.push_back(st(31'h44, 1'b0, 3'd4, 4'd8));
        stim.push_back(s_upd(3'd2, 4'd0,  1'b0, 1'b0, 31'h0)); want.push_back(st(31'h22, 1'b1, 3'd2, 4'd0));
        stim.push_back(s_pop());                               want.push_back(st(31'h22, 1'b1, 3'd2, 4'd0));
        stim.push_back(s_push(31'h66));                        want.push_back(st(31'h66, 1'b0, 3'd3, 4'd1));
        foreach (stim[i]) begin
            apply(stim[i]);
            exp_q.push_back(want[i]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL clamp[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_priority();
        stim_t  stim[$];
        state_t want[$];
        state_t got, exp;
        stim_t  r;
        r = s_upd(3'd5, 4'd5, 1'b1, 1'b0, 31'h79);
        r.rst = 1'b1;
        stim.push_back(s_push(31'h77)); want.push_back(st(31'h77, 1'b0, 3'd4, 4'd2));
        stim.push_back(s_push(31'h78)); want.push_back(st(31'h78, 1'b0, 3'd5, 4'd3));
        stim.push_back(r);              want.push_back(st(31'h0,  1'b1, 3'd0, 4'd0));
        // Restoring onto previously written slots shows the entries cleared.
        stim.push_back(s_upd(3'd5, 4'd5, 1'b0, 1'b0, 31'h0)); want.push_back(st(31'h0, 1'b0, 3'd5, 4'd5));
        stim.push_back(s_upd(3'd2, 4'd2, 1'b0, 1'b0, 31'h0)); want.push_back(st(31'h0, 1'b0, 3'd2, 4'd2));
        stim.push_back(s_idle());       want.push_back(st(31'h0,  1'b0, 3'd2, 4'd2));
        foreach (stim[i]) begin
            apply(stim[i]);
            exp_q.push_back(want[i]);
            tick();
            got = observe();
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_priority[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_push_pop();
        test_overflow();
        test_replace();
        test_restore();
        test_clamp();
        test_reset_priority();
        apply(s_idle());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
